machine_timer: RTL and testbench
================================

MACHINE_TIMER -- requirements
Module: machine_timer

Interface
REQ-001 The block SHALL have parameter CMP_RESET, default 64'hFFFF_FFFF_FFFF_FFFF, giving the reset value of mtimecmp.
REQ-002 The block SHALL have parameter PRE_W, default 16, giving the prescaler width.
REQ-003 Port clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port reg_req  input  1  register access request, valid for one cycle.
REQ-006 Port reg_we  input  1  1 = write, 0 = read; qualified by reg_req.
REQ-007 Port reg_addr  input  3  word index: 0 mtime_lo, 1 mtime_hi, 2 mtimecmp_lo, 3 mtimecmp_hi, 4 prescale, 5 ctrl; 6 and 7 are undefined.
REQ-008 Port reg_wdata  input  32  write data; always a full-word write.
REQ-009 Port reg_rdata  output  32  read data; valid only while reg_ack = 1.
REQ-010 Port reg_ack  output  1  access response pulse.
REQ-011 Port reg_err  output  1  error flag for an undefined address; valid with reg_ack.
REQ-012 Port timer_interrupt  output  1  level interrupt to the CSR unit (drives its MTIP/MTIE path).

Function
REQ-013 ctrl[0] = EN and ctrl[1] = IE; ctrl[31:2] SHALL read 0 and ignore writes.
REQ-014 prescale SHALL use bits [PRE_W-1:0]; upper bits SHALL read 0.
REQ-015 Prescaler: while EN = 1, pre_cnt SHALL increment each cycle; when pre_cnt == prescale, pre_cnt SHALL become 0 and mtime SHALL increment by 1 in the same cycle.
REQ-016 prescale = 0 SHALL advance mtime every cycle while EN = 1.
REQ-017 While EN = 0, pre_cnt and mtime SHALL hold.
REQ-018 mtime SHALL be 64 bits and SHALL wrap from all-ones to 0 with no flag.
REQ-019 A write to prescale SHALL clear pre_cnt.
REQ-020 Handshake: every cycle with reg_req = 1 SHALL be accepted; reg_ack SHALL be 1 for exactly one cycle, the next cycle.
REQ-021 Back-to-back requests SHALL be supported at one per cycle.
REQ-022 Writes SHALL take effect at the accepting edge.
REQ-023 A write to mtime_lo or mtime_hi SHALL replace that half, SHALL override the increment that cycle for the whole 64-bit value (the other half holds), and SHALL clear pre_cnt.
REQ-024 Atomic read: a read of mtime_lo SHALL return mtime[31:0] and capture mtime[63:32] into a shadow register in the same edge.
REQ-025 A read of mtime_hi SHALL return the shadow value.
REQ-026 The shadow register SHALL reset to 0 and change only on mtime_lo reads.
REQ-027 Reads of mtimecmp_lo/hi, prescale and ctrl SHALL return their values as of the accepting edge, before that edge's update.
REQ-028 An access to address 6 or 7 SHALL return reg_ack = 1, reg_err = 1 and reg_rdata = 0, with no state change.
REQ-029 reg_err SHALL be 0 for addresses 0-5; reg_rdata SHALL be 0 whenever reg_ack = 0 and for write responses.
REQ-030 Interrupt: timer_interrupt SHALL be registered and SHALL equal IE && (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on the register values of the previous cycle (one-cycle latency).
REQ-031 timer_interrupt SHALL be level-sensitive with no internal pending latch; it clears only by raising mtimecmp, lowering mtime, or clearing IE.
REQ-032 A half-written mtimecmp MAY cause a transient assertion; software writes mtimecmp_hi = all-ones first, then lo, then hi.

Reset
REQ-033 While rst = 1, the block SHALL hold: mtime = 0, pre_cnt = 0, shadow = 0, mtimecmp = CMP_RESET, prescale = 0, ctrl = 0, reg_ack = 0, reg_err = 0, reg_rdata = 0, timer_interrupt = 0.
REQ-034 A request in flight when rst asserts SHALL be dropped with no ack after reset.
REQ-035 After reset the timer SHALL stay stopped until EN is written to 1.

Verification
REQ-036 Tick: after reset, write prescale = 3 and ctrl = 1 -> mtime increments once every 4 cycles; mtime = 2 after 8 counted cycles.
REQ-037 Rollover read: mtime = 0x0000_0000_FFFF_FFFF with EN = 1 and prescale = 0; read lo -> 0xFFFF_FFFF, then read hi -> 0 (shadow), even though mtime_hi is now 1.
REQ-038 Interrupt: mtimecmp = 10, ctrl = 3, prescale = 0 -> timer_interrupt rises one cycle after mtime reaches 10; writing mtimecmp_lo = 100 drops it one cycle after the write edge.
REQ-039 IE masking: mtime > mtimecmp with ctrl = 1 -> timer_interrupt = 0; writing ctrl = 3 -> 1 on the following cycle.
REQ-040 Handshake/error: back-to-back read addr 5 then read addr 7 -> two consecutive ack pulses, the second with reg_err = 1 and reg_rdata = 0; no state change.
REQ-041 Collision/reset: write mtime_lo = 5 on a tick cycle -> mtime = 5, not 6; assert rst mid-access -> no ack and all outputs 0 after reset.

Source files
------------

// File: rtl/machine_timer.sv
// machine_timer: 64-bit RISC-V style mtime/mtimecmp timer with a programmable
// prescaler and a single-cycle register port.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous, active-high reset
//   reg_req         register access request (one cycle per access)
//   reg_we          1 = write, 0 = read
//   reg_addr        word index: 0 mtime_lo, 1 mtime_hi, 2 mtimecmp_lo,
//                   3 mtimecmp_hi, 4 prescale, 5 ctrl (6/7 undefined)
//   reg_wdata       full-word write data
//   reg_rdata       read data, valid with reg_ack (0 otherwise and for writes)
//   reg_ack         response pulse, one cycle after each request
//   reg_err         undefined-address flag, valid with reg_ack
//   timer_interrupt registered level interrupt: IE && (mtime >= mtimecmp)
//
// PRE_W must be in 1..32 since prescale is written from a single data word.
module machine_timer #(
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int unsigned PRE_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_req,
  input  logic        reg_we,
  input  logic [2:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_ack,
  output logic        reg_err,
  output logic        timer_interrupt
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TIME_W = 64;

  localparam logic [2:0] ADDR_MTIME_LO = 3'd0;
  localparam logic [2:0] ADDR_MTIME_HI = 3'd1;
  localparam logic [2:0] ADDR_CMP_LO   = 3'd2;
  localparam logic [2:0] ADDR_CMP_HI   = 3'd3;
  localparam logic [2:0] ADDR_PRESCALE = 3'd4;
  localparam logic [2:0] ADDR_CTRL     = 3'd5;

  // Architectural state
  logic [TIME_W-1:0] mtime, mtime_nxt;
  logic [TIME_W-1:0] mtimecmp, mtimecmp_nxt;
  logic [PRE_W-1:0]  pre_cnt, pre_cnt_nxt;
  logic [PRE_W-1:0]  prescale, prescale_nxt;
  logic [DATA_W-1:0] shadow, shadow_nxt;
  logic              en, en_nxt;
  logic              ie, ie_nxt;

  // Registered response / interrupt
  logic [DATA_W-1:0] rdata_nxt;
  logic              ack_nxt;
  logic              err_nxt;
  logic              irq_nxt;

  logic              tick;
  logic              wr;
  logic              rd;
  logic              addr_bad;

  // Next-state computation: prescaler tick first, register writes override.
  always_comb begin
    mtime_nxt    = mtime;
    mtimecmp_nxt = mtimecmp;
    pre_cnt_nxt  = pre_cnt;
    prescale_nxt = prescale;
    shadow_nxt   = shadow;
    en_nxt       = en;
    ie_nxt       = ie;
    rdata_nxt    = '0;
    ack_nxt      = reg_req;
    err_nxt      = 1'b0;
    irq_nxt      = ie && (mtime >= mtimecmp);

    tick     = en && (pre_cnt == prescale);
    wr       = reg_req && reg_we;
    rd       = reg_req && !reg_we;
    addr_bad = (reg_addr[2:1] == 2'b11);

    if (en) begin
      if (tick) begin
        pre_cnt_nxt = '0;
        mtime_nxt   = mtime + TIME_W'(1);
      end else begin
        pre_cnt_nxt = pre_cnt + PRE_W'(1);
      end
    end

    if (wr) begin
      unique case (reg_addr)
        ADDR_MTIME_LO: begin
          mtime_nxt   = {mtime[63:32], reg_wdata};
          pre_cnt_nxt = '0;
        end
        ADDR_MTIME_HI: begin
          mtime_nxt   = {reg_wdata, mtime[31:0]};
          pre_cnt_nxt = '0;
        end
        ADDR_CMP_LO:   mtimecmp_nxt = {mtimecmp[63:32], reg_wdata};
        ADDR_CMP_HI:   mtimecmp_nxt = {reg_wdata, mtimecmp[31:0]};
        ADDR_PRESCALE: begin
          prescale_nxt = reg_wdata[PRE_W-1:0];
          pre_cnt_nxt  = '0;
        end
        ADDR_CTRL: begin
          en_nxt = reg_wdata[0];
          ie_nxt = reg_wdata[1];
        end
        default: ;
      endcase
    end

    // Reads return pre-edge values; a lo read snapshots the upper half so a
    // following hi read is coherent with it.
    if (rd) begin
      unique case (reg_addr)
        ADDR_MTIME_LO: begin
          rdata_nxt  = mtime[31:0];
          shadow_nxt = mtime[63:32];
        end
        ADDR_MTIME_HI: rdata_nxt = shadow;
        ADDR_CMP_LO:   rdata_nxt = mtimecmp[31:0];
        ADDR_CMP_HI:   rdata_nxt = mtimecmp[63:32];
        ADDR_PRESCALE: rdata_nxt = DATA_W'(prescale);
        ADDR_CTRL:     rdata_nxt = {30'b0, ie, en};
        default:       rdata_nxt = '0;
      endcase
    end

    if (reg_req && addr_bad) begin
      err_nxt = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime           <= '0;
      mtimecmp        <= CMP_RESET;
      pre_cnt         <= '0;
      prescale        <= '0;
      shadow          <= '0;
      en              <= 1'b0;
      ie              <= 1'b0;
      reg_rdata       <= '0;
      reg_ack         <= 1'b0;
      reg_err         <= 1'b0;
      timer_interrupt <= 1'b0;
    end else begin
      mtime           <= mtime_nxt;
      mtimecmp        <= mtimecmp_nxt;
      pre_cnt         <= pre_cnt_nxt;
      prescale        <= prescale_nxt;
      shadow          <= shadow_nxt;
      en              <= en_nxt;
      ie              <= ie_nxt;
      reg_rdata       <= rdata_nxt;
      reg_ack         <= ack_nxt;
      reg_err         <= err_nxt;
      timer_interrupt <= irq_nxt;
    end
  end

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench for machine_timer: expected responses are queued when a
// request is driven and compared when the matching ack arrives.
module tb_machine_timer;

  logic        clk;
  logic        rst;
  logic        reg_req;
  logic        reg_we;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic        reg_err;
  logic        timer_interrupt;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] sb[$];   // {err, rdata}
  logic        req_q;

  machine_timer #(
    .CMP_RESET (64'hFFFF_FFFF_FFFF_FFFF),
    .PRE_W     (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .reg_req         (reg_req),
    .reg_we          (reg_we),
    .reg_addr        (reg_addr),
    .reg_wdata       (reg_wdata),
    .reg_rdata       (reg_rdata),
    .reg_ack         (reg_ack),
    .reg_err         (reg_err),
    .timer_interrupt (timer_interrupt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Bench-side record of which edges accepted a request.
  always @(posedge clk or posedge rst) begin
    if (rst) req_q <= 1'b0;
    else     req_q <= reg_req;
  end

  // Response monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [32:0] e;
    check("ack", {63'b0, reg_ack}, {63'b0, req_q});
    if (reg_ack) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("rdata", 64'(reg_rdata), 64'(e[31:0]));
        check("err", {63'b0, reg_err}, {63'b0, e[32]});
      end
    end else begin
      check("idle_out", {31'b0, reg_err, reg_rdata}, 64'd0);
    end
  end

  // One request per call; starts just after a falling edge, returns one cycle later.
  task automatic bus(input logic we, input logic [2:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err);
    reg_req   = 1'b1;
    reg_we    = we;
    reg_addr  = a;
    reg_wdata = d;
    sb.push_back({exp_err, exp_rd});
    @(negedge clk);
    reg_req = 1'b0;
    reg_we  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp);
    bus(1'b0, a, 32'h0, exp, 1'b0);
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check(tag, {63'b0, timer_interrupt}, {63'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    reg_req   = 1'b0;
    reg_we    = 1'b0;
    reg_addr  = 3'd0;
    reg_wdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", {63'b0, reg_ack}, 64'd0);
    check("rst_err", {63'b0, reg_err}, 64'd0);
    check("rst_rdata", 64'(reg_rdata), 64'd0);
    check_irq("rst_irq", 1'b0);
    rst = 1'b0;

    // Stopped after reset; register reset values
    repeat (5) @(negedge clk);
    rd(3'd0, 32'h0);
    rd(3'd1, 32'h0);
    rd(3'd2, 32'hFFFF_FFFF);
    rd(3'd3, 32'hFFFF_FFFF);
    rd(3'd4, 32'h0);
    rd(3'd5, 32'h0);

    // Tick: prescale 3 -> one increment per 4 counted cycles
    wr(3'd4, 32'd3);
    wr(3'd5, 32'd1);
    repeat (8) @(negedge clk);
    rd(3'd0, 32'd2);
    rd(3'd1, 32'd0);
    wr(3'd5, 32'd0);
    repeat (4) @(negedge clk);
    rd(3'd0, 32'd2);

    // Field widths
    wr(3'd4, 32'hABCD_1234);
    rd(3'd4, 32'h0000_1234);
    wr(3'd5, 32'hFFFF_FFFC);
    rd(3'd5, 32'h0);

    // Rollover read through the shadow register
    wr(3'd4, 32'd0);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'h0);
    wr(3'd5, 32'd1);
    rd(3'd0, 32'hFFFF_FFFF);
    rd(3'd1, 32'h0);
    rd(3'd0, 32'd1);
    rd(3'd1, 32'd1);
    wr(3'd5, 32'd0);
    rd(3'd0, 32'd4);
    rd(3'd1, 32'd1);

    // 64-bit wrap from all-ones
    wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd5, 32'd1);
    rd(3'd0, 32'hFFFF_FFFF);
    rd(3'd1, 32'hFFFF_FFFF);
    rd(3'd0, 32'd1);
    rd(3'd1, 32'd0);
    wr(3'd5, 32'd0);
    rd(3'd0, 32'd4);

    // Interrupt at mtime == mtimecmp, one cycle late
    wr(3'd3, 32'h0);
    wr(3'd2, 32'd10);
    wr(3'd0, 32'd0);
    wr(3'd5, 32'd3);
    repeat (9) @(negedge clk);
    check_irq("irq_mt9", 1'b0);
    @(negedge clk);
    check_irq("irq_mt10_lat", 1'b0);
    @(negedge clk);
    check_irq("irq_rise", 1'b1);
    wr(3'd2, 32'd100);
    check_irq("irq_hold_wr", 1'b1);
    @(negedge clk);
    check_irq("irq_drop", 1'b0);

    // IE masking
    wr(3'd5, 32'd1);
    wr(3'd2, 32'd5);
    repeat (3) begin
      @(negedge clk);
      check_irq("irq_masked", 1'b0);
    end
    wr(3'd5, 32'd3);
    check_irq("irq_ie_lat", 1'b0);
    @(negedge clk);
    check_irq("irq_ie_on", 1'b1);
    wr(3'd5, 32'd2);
    @(negedge clk);
    check_irq("irq_level", 1'b1);

    // Back-to-back, undefined addresses, no state change
    rd(3'd5, 32'd2);
    bus(1'b0, 3'd7, 32'h0, 32'h0, 1'b1);
    bus(1'b1, 3'd6, 32'hDEAD_BEEF, 32'h0, 1'b1);
    rd(3'd5, 32'd2);
    rd(3'd2, 32'd5);
    rd(3'd3, 32'd0);

    // Write collides with a tick; hi write keeps lo and suppresses the tick
    wr(3'd4, 32'd0);
    wr(3'd5, 32'd1);
    wr(3'd0, 32'd5);
    rd(3'd0, 32'd5);
    rd(3'd0, 32'd6);
    wr(3'd1, 32'd2);
    rd(3'd0, 32'd7);
    rd(3'd1, 32'd2);

    // Reset in the middle of an access
    @(negedge clk);
    reg_req  = 1'b1;
    reg_we   = 1'b0;
    reg_addr = 3'd5;
    #2 rst = 1'b1;
    @(negedge clk);
    reg_req = 1'b0;
    check("mrst_ack", {63'b0, reg_ack}, 64'd0);
    check_irq("mrst_irq", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("prst_ack", {63'b0, reg_ack}, 64'd0);
    check("prst_rdata", 64'(reg_rdata), 64'd0);
    check("prst_err", {63'b0, reg_err}, 64'd0);
    check_irq("prst_irq", 1'b0);
    repeat (4) @(negedge clk);
    rd(3'd5, 32'd0);
    rd(3'd2, 32'hFFFF_FFFF);
    rd(3'd0, 32'd0);
    rd(3'd1, 32'd0);

    repeat (3) @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
